// File: rtl/example_pkg.sv
// Shared widths and the Fletcher-16 modulus.
// Imported by the checksum datapath and its adder.
package example_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 8;
    localparam int OUT_W  = 16;

    localparam logic [SUM_W:0] MOD = 9'd255;

endpackage

// File: rtl/example_add_mod255.sv
// Combinational modulo-255 adder for one Fletcher-16 running sum.
// Operand a is a reduced sum (0..254), b may be any byte.
module add_mod255
    import example_pkg::*;
(
    input  logic [SUM_W-1:0] a,
    input  logic [SUM_W-1:0] b,
    output logic [SUM_W-1:0] result
);

    logic [SUM_W:0] s;
    logic [SUM_W:0] s_red;

    // 254 + 255 = 509 < 510, so a single conditional subtract suffices
    always_comb begin
        s     = {1'b0, a} + {1'b0, b};
        s_red = s;
        if (s >= MOD) begin
            s_red = s - MOD;
        end
        result = s_red[SUM_W-1:0];
    end

endmodule

// File: rtl/example.sv
// Fletcher-16 checksum over a byte stream, one byte per clock.
// Output is the registered pair {sum2, sum1}.
module example
    import example_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    output logic [OUT_W-1:0]  data_out
);

    logic [SUM_W-1:0] sum1;
    logic [SUM_W-1:0] sum2;
    logic [SUM_W-1:0] sum1_next;
    logic [SUM_W-1:0] sum2_next;

    add_mod255 u_add1 (
        .a      (sum1),
        .b      (data_in),
        .result (sum1_next)
    );

    // sum2 accumulates the already-updated sum1
    add_mod255 u_add2 (
        .a      (sum2),
        .b      (sum1_next),
        .result (sum2_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sum1 <= '0;
            sum2 <= '0;
        end else begin
            sum1 <= sum1_next;
            sum2 <= sum2_next;
        end
    end

    assign data_out = {sum2, sum1};

endmodule

// File: tb/tb_example.sv
// Scoreboard bench for the Fletcher-16 block.
// A reference model fills a queue; each cycle pops and compares.
module tb_example;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic [15:0] data_out;

    int total = 0;
    int bad   = 0;
    int m1    = 0;
    int m2    = 0;

    logic [15:0] sb[$];

    always #5 clk = ~clk;

    example dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] d,
                        input string tag);
        logic [15:0] e;
        @(negedge clk);
        reset   = r;
        data_in = d;
        if (r) begin
            m1 = 0;
            m2 = 0;
        end else begin
            m1 = (m1 + int'(d)) % 255;
            m2 = (m2 + m1) % 255;
        end
        sb.push_back({m2[7:0], m1[7:0]});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(tag, data_out, e);
    endtask

    initial begin
        step(1'b1, 8'hAA, "rst");
        check("rst_const", data_out, 16'h0000);

        step(1'b0, 8'h01, "two_a");
        check("two_a_const", data_out, 16'h0101);
        step(1'b0, 8'h02, "two_b");
        check("two_b_const", data_out, 16'h0403);

        step(1'b1, 8'h00, "rst2");
        step(1'b0, 8'h55, "rep_a");
        check("rep_a_const", data_out, 16'h5555);
        step(1'b0, 8'h55, "rep_b");
        check("rep_b_const", data_out, 16'h00AA);

        step(1'b1, 8'h00, "rst3");
        step(1'b0, 8'h55, "zero_a");
        check("zero_a_const", data_out, 16'h5555);
        step(1'b0, 8'h00, "zero_b");
        check("zero_b_const", data_out, 16'hAA55);

        step(1'b1, 8'h00, "rst4");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'hFF, "ff_hold");
            check("ff_const", data_out, 16'h0000);
        end

        step(1'b1, 8'h00, "rst5");
        step(1'b0, 8'hFE, "fe_a");
        check("fe_a_const", data_out, 16'hFEFE);
        step(1'b0, 8'h01, "fe_b");
        check("fe_b_const", data_out, 16'hFE00);

        step(1'b0, 8'h33, "mid_a");
        step(1'b0, 8'h44, "mid_b");
        step(1'b1, 8'h77, "mid_rst");
        check("mid_rst_const", data_out, 16'h0000);
        step(1'b0, 8'h10, "mid_c");
        check("mid_c_const", data_out, 16'h1010);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 8'($urandom_range(0, 255)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/example.md
EXAMPLE -- requirements
Module: example

Interface
REQ-001 Parameters: none; data width fixed at 8 in, 16 out.
REQ-002 clk       input   1   sole clock; all state updates on rising edge.
REQ-003 reset     input   1   synchronous, active-high reset.
REQ-004 data_in   input   8   stream byte; one byte absorbed on every rising edge while reset is low.
REQ-005 data_out  output  16  registered Fletcher-16 checksum {sum2[7:0], sum1[7:0]} of all bytes absorbed since reset.

Function
REQ-006 The block SHALL hold two 8-bit state registers, sum1 and sum2, each always in range 0..254.
REQ-007 On each rising edge with reset low: sum1_next = mod255(sum1 + data_in); sum2_next = mod255(sum2 + sum1_next).
REQ-008 mod255(a+b): 9-bit sum s; result = s-255 if s >= 255, else s; with a <= 254 and b <= 255, the result SHALL be 0..254.
REQ-009 data_in = 0xFF SHALL be treated as congruent to 0: sum1 unchanged; sum2 still accumulates sum1.
REQ-010 data_in = 0x00 SHALL still be absorbed: sum1 unchanged, sum2 += sum1.
REQ-011 data_out SHALL equal {sum2, sum1} driven directly from registers, with no combinational path from data_in.
REQ-012 Latency: a byte sampled at edge N SHALL be reflected in data_out immediately after edge N.
REQ-013 There is no enable or valid; a byte is absorbed on every non-reset cycle.
REQ-014 No X-propagation: data_in is sampled only at rising clk edges.

Reset
REQ-015 With reset high at a rising edge, sum1 and sum2 SHALL become 0x00, so data_out = 0x0000.
REQ-016 data_in SHALL be ignored on any edge where reset is high.
REQ-017 Reset mid-stream SHALL discard all history; the first edge after reset deasserts absorbs data_in from the zero state.
REQ-018 Power-up value is undefined until the first reset edge.

Structure
REQ-019 Package example_pkg SHALL hold constants DATA_W=8, SUM_W=8, OUT_W=16 and MOD=255.
REQ-020 A sub-module add_mod255 SHALL be provided:
- inputs: 8-bit a (0..254), 8-bit b (0..255)
- output: 8-bit result
- purely combinational
REQ-021 add_mod255 SHALL be instantiated twice in chain: sum1_next feeds the sum2 adder.
REQ-022 example SHALL contain only the two state registers, the reset mux and the output concatenation.

Verification
REQ-023 Reset: reset=1 for 1 edge with data_in=0xAA -> data_out=0x0000.
REQ-024 Two-byte stream: bytes 0x01 then 0x02 -> data_out=0x0101 after edge 1, 0x0403 after edge 2.
REQ-025 Repeated byte with sum2 wrap: bytes 0x55, 0x55 -> data_out=0x5555, then 0x00AA (sum2: 0x55+0xAA=0xFF wraps to 0x00).
REQ-026 Zero byte: byte 0x55 then 0x00 -> data_out=0x5555, then 0xAA55.
REQ-027 Boundaries:
- data_in held at 0xFF from reset for 8 edges -> data_out stays 0x0000.
- bytes 0xFE then 0x01 -> 0xFEFE, then 0xFE00.
REQ-028 Mid-stream reset: after nonzero checksum, reset=1 for 1 edge with data_in=0x77, then byte 0x10 -> data_out=0x0000, then 0x1010.
